// File: rtl/adc_capture_if.sv
// Bus bundle for adc_capture: sample stream, capture control, readout port and status.
interface adc_capture_if #(
    parameter int DW = 12,
    parameter int AW = 10
);
    logic [DW-1:0]   adc_data_ch0;
    logic [DW-1:0]   adc_data_ch1;
    logic            adc_valid;
    logic            arm;
    logic            abort;
    logic            trig_mode;
    logic [DW-1:0]   trig_level;
    logic [15:0]     decim;
    logic [AW:0]     sample_len;
    logic            rd_en;
    logic [2*DW-1:0] rd_data;
    logic            rd_valid;
    logic [1:0]      state;
    logic [AW:0]     fill_count;

    modport master (
        output adc_data_ch0, adc_data_ch1, adc_valid, arm, abort,
               trig_mode, trig_level, decim, sample_len, rd_en,
        input  rd_data, rd_valid, state, fill_count
    );

    modport slave (
        input  adc_data_ch0, adc_data_ch1, adc_valid, arm, abort,
               trig_mode, trig_level, decim, sample_len, rd_en,
        output rd_data, rd_valid, state, fill_count
    );
endinterface

// File: rtl/adc_capture.sv
// Triggered, decimating two-channel ADC capture into a block-RAM buffer,
// drained one {ch1, ch0} pair per rd_en once the capture is DONE.
module adc_capture #(
    parameter int DW = 12,
    parameter int AW = 10
) (
    input logic         sys_clk,
    input logic         rst,
    adc_capture_if.slave bus
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_L   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q;
    logic [DW-1:0]   level_q;
    logic [15:0]     decim_q;
    logic [AW:0]     len_q;
    logic [15:0]     dec_cnt;
    logic [DW-1:0]   prev_ch0;
    logic            prev_vld;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     fill_q;
    logic [2*DW-1:0] rd_data_q;
    logic            rd_valid_q;
    logic            running, accept, fire, wr_en, last, arm_ok, rd_ok;

    logic [2*DW-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        running = (state_q == ARMED) || (state_q == CAPTURE);
        accept  = running && bus.adc_valid && (dec_cnt == '0);
        // An invalid prev sample blocks the level crossing, so the first
        // accepted sample after arm can never trigger in level mode.
        fire    = accept && (state_q == ARMED) &&
                  (!mode_q || (prev_vld && (prev_ch0 < level_q) &&
                               (bus.adc_data_ch0 >= level_q)));
        wr_en   = fire || (accept && (state_q == CAPTURE));
        last    = wr_en && ((fill_q + ONE_L) == len_q);
        arm_ok  = bus.arm && ((state_q == IDLE) || (state_q == DONE));
        rd_ok   = bus.rd_en && (state_q == DONE) && (fill_q != '0) && !bus.arm;

        if (bus.abort) begin
            state_d = IDLE;
            wr_en   = 1'b0;
            arm_ok  = 1'b0;
            rd_ok   = 1'b0;
        end else if (arm_ok) begin
            state_d = ARMED;
        end else if (last) begin
            state_d = DONE;
        end else if (fire) begin
            state_d = CAPTURE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode_q     <= 1'b0;
            level_q    <= '0;
            decim_q    <= '0;
            len_q      <= '0;
            dec_cnt    <= '0;
            prev_ch0   <= '0;
            prev_vld   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.abort) begin
            fill_q     <= '0;
            rd_valid_q <= 1'b0;
        end else if (arm_ok) begin
            mode_q     <= bus.trig_mode;
            level_q    <= bus.trig_level;
            decim_q    <= bus.decim;
            len_q      <= ((bus.sample_len == '0) || (bus.sample_len > DEPTH_L)) ?
                          DEPTH_L : bus.sample_len;
            dec_cnt    <= '0;
            prev_vld   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (running && bus.adc_valid)
                dec_cnt <= accept ? decim_q : dec_cnt - 16'd1;
            if (accept) begin
                prev_ch0 <= bus.adc_data_ch0;
                prev_vld <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                fill_q <= fill_q + ONE_L;
            end
            if (rd_ok) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                fill_q    <= fill_q - ONE_L;
            end
        end
    end

    // Buffer contents are deliberately not reset so the array maps to block RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_en && !rst)
            mem[wr_ptr] <= {bus.adc_data_ch1, bus.adc_data_ch0};
    end

    assign bus.state      = state_q;
    assign bus.fill_count = fill_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: table of capture scenarios drained through a read
// scoreboard, then hand-written sequences for length, arm, abort and reset corners.
module tb_adc_capture;
    localparam int DW = 12;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [2*DW-1:0] exp_q [$];
    logic [2*DW-1:0] last_rd = '0;

    always #5 clk = ~clk;

    adc_capture_if #(.DW(DW), .AW(AW)) bus ();
    adc_capture #(.DW(DW), .AW(AW)) dut (.sys_clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic             mode;
        logic [11:0]      level;
        logic [15:0]      decim;
        logic [10:0]      len;
        logic [0:7][11:0] seq;
        logic [0:3][11:0] exp_ch0;
        logic [2:0]       n;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read scoreboard: every rd_valid must match the oldest expected pair.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_valid_unexpected: got data %0h with nothing expected", bus.rd_data);
            end else begin
                last_rd = exp_q.pop_front();
                if (bus.rd_data !== last_rd) begin
                    fails++;
                    $display("FAIL rd_data: got %0h expected %0h", bus.rd_data, last_rd);
                end
            end
        end
    end

    function automatic logic [2*DW-1:0] pair(input logic [11:0] v);
        return {~v, v};
    endfunction

    // Arm, then scramble config inputs: the capture must keep the latched copy.
    task automatic do_arm(input logic mode, input logic [11:0] level,
                          input logic [15:0] decim, input logic [10:0] len);
        bus.trig_mode = mode; bus.trig_level = level;
        bus.decim = decim; bus.sample_len = len;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        bus.trig_mode = ~mode; bus.trig_level = 12'h000;
        bus.decim = 16'd5; bus.sample_len = 11'd1;
        chk("arm_state", 32'(bus.state), 32'd1);
    endtask

    task automatic feed(input logic [11:0] v);
        bus.adc_valid = 1'b1; bus.adc_data_ch0 = v; bus.adc_data_ch1 = ~v;
        step();
        bus.adc_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            bus.rd_en = 1'b1;
            step();
        end
        bus.rd_en = 1'b0;
        step();
        step();
    endtask

    initial begin
        bus.adc_data_ch0 = '0; bus.adc_data_ch1 = '0; bus.adc_valid = 1'b1;
        bus.arm = 1'b1; bus.abort = 1'b0; bus.trig_mode = 1'b0;
        bus.trig_level = '0; bus.decim = '0; bus.sample_len = '0; bus.rd_en = 1'b1;

        vecs[0] = '{mode:1'b0, level:12'h000, decim:16'd0, len:11'd4,
                    seq:{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8},
                    exp_ch0:{12'd1, 12'd2, 12'd3, 12'd4}, n:3'd4};
        vecs[1] = '{mode:1'b0, level:12'h000, decim:16'd2, len:11'd3,
                    seq:{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7},
                    exp_ch0:{12'd0, 12'd3, 12'd6, 12'd0}, n:3'd3};
        vecs[2] = '{mode:1'b1, level:12'h800, decim:16'd0, len:11'd2,
                    seq:{12'h7F0, 12'h7FF, 12'h800, 12'h900, 12'h100, 12'h200, 12'h300, 12'h400},
                    exp_ch0:{12'h800, 12'h900, 12'h000, 12'h000}, n:3'd2};
        vecs[3] = '{mode:1'b1, level:12'h800, decim:16'd0, len:11'd2,
                    seq:{12'h900, 12'h700, 12'h850, 12'h860, 12'h870, 12'h880, 12'h890, 12'h8A0},
                    exp_ch0:{12'h850, 12'h860, 12'h000, 12'h000}, n:3'd2};
        vecs[4] = '{mode:1'b0, level:12'h000, decim:16'd1, len:11'd1,
                    seq:{12'd5, 12'd6, 12'd7, 12'd8, 12'd9, 12'd10, 12'd11, 12'd12},
                    exp_ch0:{12'd5, 12'd0, 12'd0, 12'd0}, n:3'd1};
        vecs[5] = '{mode:1'b1, level:12'h010, decim:16'd1, len:11'd2,
                    seq:{12'h008, 12'h009, 12'h00F, 12'h020, 12'h030, 12'h040, 12'h050, 12'h060},
                    exp_ch0:{12'h030, 12'h050, 12'h000, 12'h000}, n:3'd2};

        // Reset overrides arm/rd_en/adc_valid held high.
        step(); step();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_fill", 32'(bus.fill_count), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0; bus.arm = 1'b0; bus.adc_valid = 1'b0; bus.rd_en = 1'b0;
        step();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("idle_rd_ignored", 32'(bus.rd_valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_arm(vecs[i].mode, vecs[i].level, vecs[i].decim, vecs[i].len);
            for (int j = 0; j < 8; j++) feed(vecs[i].seq[j]);
            step();
            chk($sformatf("v%0d_state", i), 32'(bus.state), 32'd3);
            chk($sformatf("v%0d_fill", i), 32'(bus.fill_count), 32'(vecs[i].n));
            for (int k = 0; k < int'(vecs[i].n); k++) exp_q.push_back(pair(vecs[i].exp_ch0[k]));
            drain(int'(vecs[i].n));
            chk($sformatf("v%0d_sb_empty", i), 32'(exp_q.size()), 32'd0);
            chk($sformatf("v%0d_fill_empty", i), 32'(bus.fill_count), 32'd0);
            bus.rd_en = 1'b1;
            step();
            bus.rd_en = 1'b0;
            chk($sformatf("v%0d_extra_rd", i), 32'(bus.rd_valid), 32'd0);
            chk($sformatf("v%0d_rd_hold", i), 32'(bus.rd_data), 32'(pair(vecs[i].exp_ch0[vecs[i].n - 1])));
        end

        // Length 0 means the full 1024-pair buffer.
        do_arm(1'b0, 12'h000, 16'd0, 11'd0);
        for (int i = 0; i < 1030; i++) feed(12'(i));
        step();
        chk("full_state", 32'(bus.state), 32'd3);
        chk("full_fill", 32'(bus.fill_count), 32'd1024);
        for (int i = 0; i < 1024; i++) exp_q.push_back(pair(12'(i)));
        drain(1024);
        chk("full_sb_empty", 32'(exp_q.size()), 32'd0);

        // Arm during CAPTURE is ignored, including its new length.
        do_arm(1'b0, 12'h000, 16'd0, 11'd4);
        feed(12'd1);
        bus.arm = 1'b1; bus.sample_len = 11'd2;
        feed(12'd2);
        bus.arm = 1'b0;
        chk("arm_in_capture_state", 32'(bus.state), 32'd2);
        chk("arm_in_capture_fill", 32'(bus.fill_count), 32'd2);
        feed(12'd3); feed(12'd4);
        chk("arm_in_capture_done", 32'(bus.state), 32'd3);
        chk("arm_in_capture_len", 32'(bus.fill_count), 32'd4);

        // Arm and rd_en together in DONE: arm wins, no read.
        bus.arm = 1'b1; bus.rd_en = 1'b1;
        step();
        bus.arm = 1'b0; bus.rd_en = 1'b0;
        chk("arm_rd_state", 32'(bus.state), 32'd1);
        chk("arm_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("arm_rd_fill", 32'(bus.fill_count), 32'd0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_armed_state", 32'(bus.state), 32'd0);

        // Abort at pair 2 of 8 beats a simultaneous sample.
        do_arm(1'b0, 12'h000, 16'd0, 11'd8);
        feed(12'd1); feed(12'd2);
        bus.abort = 1'b1;
        feed(12'd3);
        bus.abort = 1'b0;
        chk("abort_cap_state", 32'(bus.state), 32'd0);
        chk("abort_cap_fill", 32'(bus.fill_count), 32'd0);

        // Abort in DONE suppresses a same-cycle read.
        do_arm(1'b0, 12'h000, 16'd0, 11'd2);
        feed(12'd9); feed(12'd10);
        chk("abort_done_pre", 32'(bus.state), 32'd3);
        bus.abort = 1'b1; bus.rd_en = 1'b1;
        step();
        bus.abort = 1'b0; bus.rd_en = 1'b0;
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("abort_rd_state", 32'(bus.state), 32'd0);
        chk("abort_rd_fill", 32'(bus.fill_count), 32'd0);

        // Reset mid-capture overrides everything and clears rd_data.
        do_arm(1'b0, 12'h000, 16'd0, 11'd8);
        feed(12'd1); feed(12'd2); feed(12'd3);
        rst = 1'b1; bus.arm = 1'b1; bus.rd_en = 1'b1; bus.abort = 1'b1;
        feed(12'd4);
        chk("rst_cap_state", 32'(bus.state), 32'd0);
        chk("rst_cap_fill", 32'(bus.fill_count), 32'd0);
        chk("rst_cap_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_cap_rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0; bus.arm = 1'b0; bus.rd_en = 1'b0; bus.abort = 1'b0;
        step();
        chk("rst_cap_idle", 32'(bus.state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
